// File: rtl/cpu_pkg.sv
// Shared CPU-wide widths, memory geometry and the fetch queue entry type.
package cpu_pkg;

  localparam int WORD_WIDTH  = 16;
  localparam int ADDR_WIDTH  = 16;
  localparam int MEM_DEPTH   = 1024;
  localparam int INSTR_BYTES = 2;
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = 16'h0000;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Memory read port, decode handshake and redirect/fault signals of the fetch stage.
interface fetch_unit_if
  import cpu_pkg::*;
();

  logic [ADDR_WIDTH-1:0] mem_address;
  logic [WORD_WIDTH-1:0] mem_data;
  logic                  mem_grant;
  logic                  instr_valid;
  logic [WORD_WIDTH-1:0] instr;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_pc;
  logic                  fetch_fault;

  modport master (
    output mem_address,
    input  mem_data,
    input  mem_grant,
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_fault
  );

  modport slave (
    input  mem_address,
    output mem_data,
    output mem_grant,
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready,
    output redirect_valid,
    output redirect_pc,
    input  fetch_fault
  );

endinterface

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush.
// Head data reads zero whenever the queue is empty.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             nrst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  fetch_entry_t     wr_data,
  output fetch_entry_t     rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     storage [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage is never reset; only the pointers and count carry state that matters.
  always_ff @(posedge clock) begin
    if (do_push && !flush) storage[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  assign rd_data = empty ? '0 : storage[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, push/redirect/fault control and prefetch queue.
// The memory read is combinational, so a word is captured in the cycle its address is granted.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int                    MEM_DEPTH = cpu_pkg::MEM_DEPTH,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC  = cpu_pkg::RESET_PC,
  parameter int                    QDEPTH    = 2
) (
  input logic          clock,
  input logic          nrst,
  fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MEM_DEPTH - INSTR_BYTES);

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  fault;
  logic                  in_range;
  logic                  pop;
  logic                  push;
  logic                  q_full;
  logic                  q_empty;
  logic [CNT_W-1:0]      q_count;
  logic                  count_unused;
  fetch_entry_t          q_in;
  fetch_entry_t          q_head;

  assign in_range = (fetch_pc <= LAST_ADDR);
  assign pop      = ~q_empty & bus.instr_ready;
  assign push     = bus.mem_grant & ~fault & ~bus.redirect_valid & (~q_full | pop) & in_range;
  assign q_in     = '{instr: bus.mem_data, pc: fetch_pc};
  assign count_unused = ^q_count;

  // Redirect outranks everything: it flushes, retargets the PC and clears the fault.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      fetch_pc <= RESET_PC;
      fault    <= 1'b0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= {bus.redirect_pc[ADDR_WIDTH-1:1], 1'b0};
      fault    <= 1'b0;
    end else begin
      if (push) fetch_pc <= fetch_pc + ADDR_WIDTH'(INSTR_BYTES);
      if (bus.mem_grant && !in_range) fault <= 1'b1;
    end
  end

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_queue (
    .clock   (clock),
    .nrst    (nrst),
    .push    (push),
    .pop     (pop & ~bus.redirect_valid),
    .flush   (bus.redirect_valid),
    .wr_data (q_in),
    .rd_data (q_head),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  assign bus.mem_address = fetch_pc;
  assign bus.instr_valid = ~q_empty;
  assign bus.instr       = q_head.instr;
  assign bus.instr_pc    = q_head.pc;
  assign bus.fetch_fault = fault;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, hand-written corner sequences
// and randomized traffic against a queue-based reference model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int QD = 2;

  logic clock = 1'b0;
  logic nrst  = 1'b0;

  fetch_unit_if bus ();

  fetch_unit #(
    .MEM_DEPTH (1024),
    .RESET_PC  (16'h0000),
    .QDEPTH    (QD)
  ) dut (
    .clock (clock),
    .nrst  (nrst),
    .bus   (bus.master)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    if (a == 16'h0000) return 16'h1234;
    if (a == 16'h0002) return 16'hABCD;
    return 16'hC000 | a;
  endfunction

  assign bus.mem_data = word_at(bus.mem_address);

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
  } ent_t;

  ent_t        mq[$];
  logic [15:0] m_pc;
  logic        m_fault;

  int tests = 0;
  int fails = 0;

  task automatic model_reset();
    mq.delete();
    m_pc    = 16'h0000;
    m_fault = 1'b0;
  endtask

  // One clock of fetch behaviour expressed directly as queue operations.
  task automatic model_step(input logic g, input logic r, input logic rv, input logic [15:0] rpc);
    logic pop_now, push_now, in_rng;
    if (rv) begin
      mq.delete();
      m_pc    = rpc & 16'hFFFE;
      m_fault = 1'b0;
      return;
    end
    in_rng   = (m_pc <= 16'd1022);
    pop_now  = (mq.size() > 0) && r;
    push_now = g && !m_fault && in_rng && ((mq.size() < QD) || pop_now);
    if (pop_now) void'(mq.pop_front());
    if (push_now) begin
      mq.push_back('{instr: word_at(m_pc), pc: m_pc});
      m_pc = m_pc + 16'd2;
    end
    if (g && !in_rng) m_fault = 1'b1;
  endtask

  task automatic compare(input string name, input logic ev, input logic [15:0] ei,
                         input logic [15:0] ep, input logic [15:0] ea, input logic ef);
    tests++;
    if (bus.instr_valid !== ev || bus.instr !== ei || bus.instr_pc !== ep ||
        bus.mem_address !== ea || bus.fetch_fault !== ef) begin
      fails++;
      $display("FAIL %s: got valid=%0b instr=%h pc=%h addr=%h fault=%0b, want valid=%0b instr=%h pc=%h addr=%h fault=%0b",
               name, bus.instr_valid, bus.instr, bus.instr_pc, bus.mem_address, bus.fetch_fault,
               ev, ei, ep, ea, ef);
    end
  endtask

  task automatic check_model(input string name);
    logic        ev;
    logic [15:0] ei, ep;
    ev = (mq.size() > 0);
    ei = ev ? mq[0].instr : 16'h0000;
    ep = ev ? mq[0].pc    : 16'h0000;
    compare(name, ev, ei, ep, m_pc, m_fault);
  endtask

  task automatic cycle(input logic g, input logic r, input logic rv, input logic [15:0] rpc);
    bus.mem_grant      = g;
    bus.instr_ready    = r;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    model_step(g, r, rv, rpc);
    @(posedge clock);
    #1;
  endtask

  typedef struct {
    logic        g, r, rv;
    logic [15:0] rpc;
    logic        ev;
    logic [15:0] ei, ep, ea;
    logic        ef;
  } vec_t;

  function automatic vec_t mk(logic g, logic r, logic rv, logic [15:0] rpc, logic ev,
                              logic [15:0] ei, logic [15:0] ep, logic [15:0] ea, logic ef);
    vec_t v;
    v.g = g; v.r = r; v.rv = rv; v.rpc = rpc;
    v.ev = ev; v.ei = ei; v.ep = ep; v.ea = ea; v.ef = ef;
    return v;
  endfunction

  vec_t vt [19];

  initial begin
    // fill, stall at full, drain, redirect while full, grant toggling, fault and recovery
    vt[0]  = mk(1, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0002, 0);
    vt[1]  = mk(1, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0004, 0);
    vt[2]  = mk(1, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0004, 0);
    vt[3]  = mk(1, 0, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0004, 0);
    vt[4]  = mk(1, 1, 0, 16'h0000, 1, 16'hABCD, 16'h0002, 16'h0006, 0);
    vt[5]  = mk(1, 1, 0, 16'h0000, 1, 16'hC004, 16'h0004, 16'h0008, 0);
    vt[6]  = mk(1, 1, 0, 16'h0000, 1, 16'hC006, 16'h0006, 16'h000A, 0);
    vt[7]  = mk(1, 1, 1, 16'h0101, 0, 16'h0000, 16'h0000, 16'h0100, 0);
    vt[8]  = mk(1, 1, 0, 16'h0000, 1, 16'hC100, 16'h0100, 16'h0102, 0);
    vt[9]  = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0102, 0);
    vt[10] = mk(1, 1, 0, 16'h0000, 1, 16'hC102, 16'h0102, 16'h0104, 0);
    vt[11] = mk(0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0104, 0);
    vt[12] = mk(1, 1, 0, 16'h0000, 1, 16'hC104, 16'h0104, 16'h0106, 0);
    vt[13] = mk(1, 1, 1, 16'h03FE, 0, 16'h0000, 16'h0000, 16'h03FE, 0);
    vt[14] = mk(1, 1, 0, 16'h0000, 1, 16'hC3FE, 16'h03FE, 16'h0400, 0);
    vt[15] = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0400, 1);
    vt[16] = mk(1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0400, 1);
    vt[17] = mk(0, 1, 1, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0000, 0);
    vt[18] = mk(1, 1, 0, 16'h0000, 1, 16'h1234, 16'h0000, 16'h0002, 0);

    bus.mem_grant      = 1'b0;
    bus.instr_ready    = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    model_reset();

    #12;
    compare("reset_state", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    @(negedge clock);
    nrst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      cycle(vt[i].g, vt[i].r, vt[i].rv, vt[i].rpc);
      compare($sformatf("vec%0d", i), vt[i].ev, vt[i].ei, vt[i].ep, vt[i].ea, vt[i].ef);
    end

    // Fault raised while the queue is full; queued words keep draining.
    cycle(1, 0, 1, 16'h03FD);
    check_model("near_end_redirect");
    cycle(1, 0, 0, 16'h0000);
    cycle(1, 0, 0, 16'h0000);
    compare("full_at_end", 1'b1, 16'hC3FC, 16'h03FC, 16'h0400, 1'b0);
    cycle(1, 0, 0, 16'h0000);
    compare("fault_with_queue", 1'b1, 16'hC3FC, 16'h03FC, 16'h0400, 1'b1);
    cycle(1, 1, 0, 16'h0000);
    compare("drain_under_fault", 1'b1, 16'hC3FE, 16'h03FE, 16'h0400, 1'b1);

    // Asynchronous reset between edges with a word queued and the fault set.
    #3;
    nrst = 1'b0;
    model_reset();
    #1;
    compare("async_reset", 1'b0, 16'h0000, 16'h0000, 16'h0000, 1'b0);
    @(negedge clock);
    nrst = 1'b1;
    cycle(1, 1, 0, 16'h0000);
    compare("restart_after_reset", 1'b1, 16'h1234, 16'h0000, 16'h0002, 1'b0);
    cycle(1, 1, 0, 16'h0000);
    compare("restart_second", 1'b1, 16'hABCD, 16'h0002, 16'h0004, 1'b0);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      logic        g, r, rv;
      logic [15:0] rpc;
      g   = ($urandom % 4) != 0;
      r   = ($urandom % 3) != 0;
      rv  = ($urandom % 16) == 0;
      rpc = (($urandom % 4) == 0) ? 16'($urandom_range(16'h03F0, 16'h0420))
                                  : 16'($urandom_range(0, 16'h03FF));
      cycle(g, r, rv, rpc);
      check_model($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
